// File: rtl/array_pkg.sv
// Shared constants and types for the cache data-array request scheduler.
// Optional feature macro: ARRAY_INIT_CLEAR_EN (zero-fill of the array after reset).
package array_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 256;
  localparam int MASK_W     = 4;
  localparam int LANE_W     = DATA_W / MASK_W;
  localparam int RESP_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/array_resp_fifo.sv
// Small synchronous response FIFO with a fall-through path: when empty, a word
// being pushed is visible on the output in the same cycle and can be popped
// directly, so read data reaches the consumer one cycle after issue.
module array_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 256,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, bypass, do_write, do_read;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Push and pop on an empty FIFO hand the word straight through without storing it.
  assign bypass   = empty & push_i & pop_i;
  assign do_write = push_i & ~bypass;
  assign do_read  = pop_i & ~empty;

  assign valid_o  = ~empty | push_i;
  assign data_o   = empty ? push_data_i : mem_q[rd_ptr_q];
  assign count_o  = count_q;

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_write) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_read)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, written only when the word is not bypassed.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit accounting must never let a push land on a full FIFO.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full))
    else $error("array_resp_fifo: push while full");

endmodule

// File: rtl/array_rw_sched.sv
// Request scheduler in front of the cache data-array: turns a valid/ready
// request stream into the single-port RW0 interface, absorbs the 1-cycle read
// latency and queues read data for a consumer that may stall.
// Optional feature macro: ARRAY_INIT_CLEAR_EN -- zero-fills every entry after
// reset before accepting requests, and adds the init_done output.
module array_rw_sched
  import array_pkg::*;
#(
  parameter int ADDR_W     = array_pkg::ADDR_W,
  parameter int DATA_W     = array_pkg::DATA_W,
  parameter int MASK_W     = array_pkg::MASK_W,
  parameter int RESP_DEPTH = array_pkg::RESP_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
`ifdef ARRAY_INIT_CLEAR_EN
  output logic              init_done,
`endif
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic              RW0_clk,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  fsm_e             state_q;
  logic             ready_en_q;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   outstanding;
  logic             credit_ok, accept;

  // Reads still owed to the consumer: queued words plus the one arriving from the array.
  assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok   = (outstanding < (CNT_W + 1)'(RESP_DEPTH));

  // Ready is built from registered state only, so it never waits on resp_ready.
  assign req_ready   = ready_en_q & (req_wen | credit_ok);
  assign accept      = req_valid & req_ready;
  assign inflight_d  = accept & ~req_wen;

  assign RW0_clk     = clock;

`ifdef ARRAY_INIT_CLEAR_EN
  logic [ADDR_W-1:0] init_addr_q;
  logic              init_done_q;
  logic              init_write;

  // The clear sweep owns the array port while INIT, but never while reset is held.
  assign init_write = (state_q == INIT) & resetn;
  assign RW0_en     = init_write | accept;
  assign RW0_wmode  = init_write | (accept & req_wen);
  assign RW0_addr   = init_write ? init_addr_q : req_addr;
  assign RW0_wdata  = init_write ? '0 : req_wdata;
  assign RW0_wmask  = init_write ? '1 : req_wmask;
  assign init_done  = init_done_q;
`else
  assign RW0_en     = accept;
  assign RW0_wmode  = accept & req_wen;
  assign RW0_addr   = req_addr;
  assign RW0_wdata  = req_wdata;
  assign RW0_wmask  = req_wmask;
`endif

  // Mode FSM: optional clear sweep, then steady-state request acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
`ifdef ARRAY_INIT_CLEAR_EN
      state_q     <= INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
`else
      state_q     <= RUN;
`endif
      ready_en_q  <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
`ifdef ARRAY_INIT_CLEAR_EN
          init_addr_q <= init_addr_q + ADDR_W'(1);
          if (init_addr_q == '1) begin
            state_q     <= RUN;
            ready_en_q  <= 1'b1;
            init_done_q <= 1'b1;
          end
`else
          state_q <= RUN;
`endif
        end
        RUN: begin
          ready_en_q <= 1'b1;
`ifdef ARRAY_INIT_CLEAR_EN
          init_done_q <= 1'b1;
`endif
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // A read issued this cycle returns data from the array next cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  array_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .push_i      (inflight_q),
    .push_data_i (RW0_rdata),
    .pop_i       (resp_ready),
    .valid_o     (resp_valid),
    .data_o      (resp_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_array_rw_sched.sv
// Randomised scoreboard bench for array_rw_sched with a behavioural array model.
// Honours ARRAY_INIT_CLEAR_EN when defined for the whole build.
module tb_array_rw_sched;
  import array_pkg::*;

  localparam int DEPTH = RESP_DEPTH;
`ifdef ARRAY_INIT_CLEAR_EN
  localparam int READY_LAT = 4096;
`else
  localparam int READY_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [MASK_W-1:0] req_wmask = '0;
  logic              resp_valid, resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en, RW0_wmode, RW0_clk;
  logic [DATA_W-1:0] RW0_wdata;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_rdata = '0;
`ifdef ARRAY_INIT_CLEAR_EN
  logic              init_done;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  array_rw_sched dut (
    .clock      (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef ARRAY_INIT_CLEAR_EN
    .init_done  (init_done),
`endif
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wdata  (RW0_wdata),
    .RW0_wmask  (RW0_wmask),
    .RW0_clk    (RW0_clk),
    .RW0_rdata  (RW0_rdata)
  );

  // Power-on contents of the array model, so unwritten entries are recognisable.
  function automatic logic [DATA_W-1:0] init_pat(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {20'hC0FFE, a};
    return {8{w}};
  endfunction

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Behavioural single-port array with one cycle of read latency.
  logic [DATA_W-1:0] bram [1 << ADDR_W];
  bit                bram_written [1 << ADDR_W];
  always @(posedge clk) begin : bram_model
    logic [DATA_W-1:0] w;
    if (RW0_en) begin
      w = bram_written[RW0_addr] ? bram[RW0_addr] : init_pat(RW0_addr);
      if (RW0_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (RW0_wmask[l]) w[l*LANE_W +: LANE_W] = RW0_wdata[l*LANE_W +: LANE_W];
        bram[RW0_addr]         <= w;
        bram_written[RW0_addr] <= 1'b1;
      end else begin
        RW0_rdata <= w;
      end
    end
  end

  // Reference contents as the requester should see them.
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];

  typedef struct {
    logic [DATA_W-1:0] data;
    int                acc_cyc;
    bit                timed;
    logic [ADDR_W-1:0] addr;
  } exp_t;
  exp_t expq[$];

  int n_checks = 0, n_errors = 0;
  int n_rd_acc = 0, n_resp = 0, last_pop_cyc = -1;
  bit running = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every handshaken response is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got %0h, no response expected (cycle %0d)", resp_data, cyc);
      end else begin
        e = expq.pop_front();
        $display("cyc %0d: resp addr %03h data %0h", cyc, e.addr, resp_data);
        check("resp_data", resp_data, e.data);
        if (e.timed) check("resp_latency", DATA_W'(cyc), DATA_W'(e.acc_cyc + 1));
      end
      n_resp++;
      last_pop_cyc = cyc;
    end
  end

  // One clock of stimulus; readiness is predicted from outstanding reads.
  task automatic step(input bit v, input bit wen, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask,
                      input bit rr, input bit timed, output bit acc);
    int prior;
    bit exp_rdy;
    req_valid  = v;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = data;
    req_wmask  = mask;
    resp_ready = rr;
    @(negedge clk);
    #1;
    prior   = n_resp - ((last_pop_cyc == cyc) ? 1 : 0);
    exp_rdy = running && (wen || (n_rd_acc - prior) < DEPTH);
    if (v) check("req_ready", DATA_W'(req_ready), DATA_W'(exp_rdy));
    acc = v && req_ready;
    if (acc) begin
      if (wen) begin
        for (int l = 0; l < MASK_W; l++)
          if (mask[l]) ref_mem[addr][l*LANE_W +: LANE_W] = data[l*LANE_W +: LANE_W];
        $display("cyc %0d: write addr %03h mask %b", cyc, addr, mask);
      end else begin
        expq.push_back('{ref_mem[addr], cyc, timed, addr});
        n_rd_acc++;
        $display("cyc %0d: read  addr %03h", cyc, addr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr, 1'b0, a);
  endtask

  task automatic do_reset(input int hold);
    int k;
    resetn     = 1'b0;
    running    = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b1;
    resp_ready = 1'b0;
    expq.delete();
    n_rd_acc     = 0;
    n_resp       = 0;
    last_pop_cyc = -1;
`ifdef ARRAY_INIT_CLEAR_EN
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = '0;
`endif
    repeat (hold) @(negedge clk);
    check("reset_req_ready", DATA_W'(req_ready), '0);
    check("reset_resp_valid", DATA_W'(resp_valid), '0);
    check("reset_rw0_en", DATA_W'({RW0_en, RW0_wmode}), '0);
    resetn = 1'b1;
    for (k = 1; k <= 5000; k++) begin
      @(negedge clk);
`ifdef ARRAY_INIT_CLEAR_EN
      if (k == 1) check("init_done_low", DATA_W'(init_done), '0);
`endif
      if (req_ready) break;
    end
    check("ready_latency", DATA_W'(k), DATA_W'(READY_LAT));
`ifdef ARRAY_INIT_CLEAR_EN
    check("init_done_high", DATA_W'(init_done), DATA_W'(1));
`endif
    running = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    logic [DATA_W-1:0] d1, ones;
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = init_pat(ADDR_W'(a));
    #2;
    do_reset(3);

    // Write then read back the same entry.
    d1 = rand256();
    step(1'b1, 1'b1, 12'h010, d1, 4'hF, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 12'h010, '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Partial-lane write over a zeroed entry.
    ones = '1;
    step(1'b1, 1'b1, 12'h020, '0, 4'hF, 1'b1, 1'b0, acc);
    step(1'b1, 1'b1, 12'h020, ones, 4'b0010, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 12'h020, '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);
    check("partial_lane_model", ref_mem[12'h020], {128'h0, {64{1'b1}}, 64'h0});

    // Eight back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, ADDR_W'(12'h030 + i), rand256(), 4'hF, 1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, ADDR_W'(12'h030 + i), '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Stalled consumer: two reads fit, the third waits for credit.
    step(1'b1, 1'b0, 12'h030, '0, '0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 12'h031, '0, '0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 12'h032, '0, '0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 12'h032, '0, '0, 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) step(1'b1, 1'b0, 12'h032, '0, '0, 1'b1, 1'b0, acc);
    check("third_read_accepted", DATA_W'(acc), DATA_W'(1));
    idle(4, 1'b1);

    // Reset with one queued response and one read in flight.
    step(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 12'h020, '0, '0, 1'b0, 1'b0, acc);
    check("resp_valid_before_reset", DATA_W'(resp_valid), DATA_W'(1));
    resetn = 1'b0;
    #1;
    check("resp_valid_async_reset", DATA_W'(resp_valid), '0);
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
      check("no_stale_resp", DATA_W'(resp_valid), '0);
    end

    // Top entry: zero after a clear sweep, power-on pattern otherwise.
    step(1'b1, 1'b0, 12'hFFF, '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // Randomised mix over a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ADDR_W'($urandom_range(0, 15)),
           rand256(), MASK_W'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    idle(8, 1'b1);
    check("all_responses_drained", DATA_W'(expq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
